// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: mode encodings and field moduli.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN          = 2'b00,
        SET_MIN      = 2'b01,
        SET_HOUR     = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_t;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

endpackage : clock_pkg

// File: rtl/clock_time_ctrl_bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD with synchronous clear and enable.
// wrap flags the enabled increment that returns the count to 00.
module bcd_mod_counter #(
    parameter int MOD = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       wrap
);

    localparam logic [3:0] LAST_TENS  = 4'((MOD - 1) / 10);
    localparam logic [3:0] LAST_UNITS = 4'((MOD - 1) % 10);

    logic [3:0] tens_r;
    logic [3:0] units_r;
    logic       at_max_s;

    assign at_max_s = (tens_r == LAST_TENS) && (units_r == LAST_UNITS);
    assign wrap     = en && at_max_s;
    assign tens     = tens_r;
    assign units    = units_r;

    // Digit registers; clear takes precedence over an enabled increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens_r  <= 4'd0;
            units_r <= 4'd0;
        end else if (en) begin
            if (at_max_s) begin
                tens_r  <= 4'd0;
                units_r <= 4'd0;
            end else if (units_r == 4'd9) begin
                tens_r  <= tens_r + 4'd1;
                units_r <= 4'd0;
            end else begin
                tens_r  <= tens_r;
                units_r <= units_r + 4'd1;
            end
        end else begin
            tens_r  <= tens_r;
            units_r <= units_r;
        end
    end

endmodule : bcd_mod_counter

// File: rtl/clock_time_ctrl.sv
// Time-keeping controller: HH:MM:SS BCD counters, one-second prescaler and
// the RUN / SET_MIN / SET_HOUR mode machine selecting what btn_inc reaches.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] h1,
    output logic [3:0] h2,
    output logic [3:0] m1,
    output logic [3:0] m2,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic [1:0] mode,
    output logic       sec_tick
);

    localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    mode_t          mode_r;
    mode_t          mode_next_s;
    logic [PW-1:0]  presc_r;
    logic [PW-1:0]  presc_next_s;
    logic           sec_tick_r;
    logic           run_s;
    logic           tick_s;
    logic           sec_clr_s;
    logic           sec_wrap_s;
    logic           min_wrap_s;
    logic           hour_wrap_s;
    logic           min_en_s;
    logic           hour_en_s;

    assign run_s = (mode_r == RUN);

    // A mode change on a terminal-count cycle wins over the tick.
    assign tick_s    = run_s && (presc_r == PRESC_LAST) && !btn_mode;
    assign sec_clr_s = run_s && btn_mode;
    assign min_en_s  = run_s ? sec_wrap_s
                             : ((mode_r == SET_MIN) && btn_inc && !btn_mode);
    assign hour_en_s = run_s ? min_wrap_s
                             : ((mode_r == SET_HOUR) && btn_inc && !btn_mode);

    // Mode sequencing; the unused encoding recovers to RUN.
    always_comb begin
        mode_next_s = mode_r;
        case (mode_r)
            RUN:      mode_next_s = btn_mode ? SET_MIN  : RUN;
            SET_MIN:  mode_next_s = btn_mode ? SET_HOUR : SET_MIN;
            SET_HOUR: mode_next_s = btn_mode ? RUN      : SET_HOUR;
            default:  mode_next_s = RUN;
        endcase
    end

    // Prescaler is held at zero outside RUN and on the edge leaving RUN.
    always_comb begin
        presc_next_s = presc_r;
        if (!run_s || btn_mode) begin
            presc_next_s = '0;
        end else if (presc_r == PRESC_LAST) begin
            presc_next_s = '0;
        end else begin
            presc_next_s = presc_r + PW'(1);
        end
    end

    // State register for mode, prescaler and the registered tick strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r     <= RUN;
            presc_r    <= '0;
            sec_tick_r <= 1'b0;
        end else begin
            mode_r     <= mode_next_s;
            presc_r    <= presc_next_s;
            sec_tick_r <= tick_s;
        end
    end

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (tick_s),
        .clr   (sec_clr_s),
        .tens  (s1),
        .units (s2),
        .wrap  (sec_wrap_s)
    );

    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (min_en_s),
        .clr   (1'b0),
        .tens  (m1),
        .units (m2),
        .wrap  (min_wrap_s)
    );

    bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .en    (hour_en_s),
        .clr   (1'b0),
        .tens  (h1),
        .units (h2),
        .wrap  (hour_wrap_s)
    );

    assign mode     = mode_r;
    assign sec_tick = sec_tick_r;

endmodule : clock_time_ctrl

// File: tb/tb_clock_time_ctrl.sv
// Directed self-checking bench for clock_time_ctrl with TICK_DIV = 4.
module tb_clock_time_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] h1, h2, m1, m2, s1, s2;
    logic [1:0] mode;
    logic       sec_tick;

    int checks = 0;
    int errors = 0;
    logic watch_tick = 1'b0;
    logic saw_tick   = 1'b0;

    clock_time_ctrl #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .h1       (h1),
        .h2       (h2),
        .m1       (m1),
        .m2       (m2),
        .s1       (s1),
        .s2       (s2),
        .mode     (mode),
        .sec_tick (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sticky record of any sec_tick while a watch window is open.
    always @(negedge clk) begin
        if (watch_tick && sec_tick) saw_tick = 1'b1;
    end

    function automatic logic [23:0] hms();
        return {h1, h2, m1, m2, s1, s2};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1; step(1); btn_mode = 1'b0; step(1);
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1; step(1); btn_inc = 1'b0; step(1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (hms() !== 24'h000000 || mode !== 2'b00 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %h mode=%b tick=%b, want 000000 mode=00 tick=0",
                     hms(), mode, sec_tick);
        end
    endtask

    task automatic test_run();
        int pulses = 0;
        int bad_phase = 0;
        do_reset();
        for (int i = 1; i <= 240; i++) begin
            step(1);
            if (sec_tick) pulses++;
            if (sec_tick !== ((i % 4) == 0)) bad_phase++;
            if (i == 4) begin
                checks++;
                if (sec_tick !== 1'b1 || hms() !== 24'h000001) begin
                    errors++;
                    $display("FAIL first_tick: got tick=%b time=%h, want 1 000001", sec_tick, hms());
                end
            end
        end
        checks++;
        if (bad_phase != 0 || pulses != 60) begin
            errors++;
            $display("FAIL tick_period: pulses=%0d misaligned=%0d, want 60 and 0", pulses, bad_phase);
        end
        checks++;
        if (hms() !== 24'h000100) begin
            errors++;
            $display("FAIL run_240: got %h, want 000100", hms());
        end
    endtask

    task automatic test_set_min();
        do_reset();
        step(9);
        checks++;
        if (hms() !== 24'h000002) begin
            errors++;
            $display("FAIL pre_set_min: got %h, want 000002", hms());
        end
        pulse_mode();
        checks++;
        if (mode !== 2'b01 || hms() !== 24'h000000) begin
            errors++;
            $display("FAIL enter_set_min: got mode=%b time=%h, want 01 000000", mode, hms());
        end
        saw_tick = 1'b0; watch_tick = 1'b1;
        pulse_inc(61);
        step(8);
        watch_tick = 1'b0;
        checks++;
        if (hms() !== 24'h000100) begin
            errors++;
            $display("FAIL set_min_61: got %h, want 000100", hms());
        end
        checks++;
        if (saw_tick !== 1'b0) begin
            errors++;
            $display("FAIL set_no_tick: got saw_tick=%b, want 0", saw_tick);
        end
    endtask

    task automatic test_set_hour();
        do_reset();
        pulse_mode();
        pulse_mode();
        checks++;
        if (mode !== 2'b10) begin
            errors++;
            $display("FAIL enter_set_hour: got %b, want 10", mode);
        end
        pulse_inc(25);
        checks++;
        if (hms() !== 24'h010000) begin
            errors++;
            $display("FAIL set_hour_25: got %h, want 010000", hms());
        end
        pulse_mode();
        pulse_mode();
        pulse_inc(59);
        checks++;
        if (mode !== 2'b01 || hms() !== 24'h015900) begin
            errors++;
            $display("FAIL set_min_59: got mode=%b time=%h, want 01 015900", mode, hms());
        end
        pulse_inc(1);
        checks++;
        if (hms() !== 24'h010000) begin
            errors++;
            $display("FAIL set_min_wrap: got %h, want 010000", hms());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse_mode();
        pulse_inc(3);
        btn_mode = 1'b1; btn_inc = 1'b1;
        step(1);
        btn_mode = 1'b0; btn_inc = 1'b0;
        checks++;
        if (mode !== 2'b10 || hms() !== 24'h000300) begin
            errors++;
            $display("FAIL mode_wins: got mode=%b time=%h, want 10 000300", mode, hms());
        end
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        step(3);
        checks++;
        if (mode !== 2'b00 || sec_tick !== 1'b0 || hms() !== 24'h000300) begin
            errors++;
            $display("FAIL run_restart_early: got mode=%b tick=%b time=%h, want 00 0 000300",
                     mode, sec_tick, hms());
        end
        step(1);
        checks++;
        if (sec_tick !== 1'b1 || hms() !== 24'h000301) begin
            errors++;
            $display("FAIL run_restart_tick: got tick=%b time=%h, want 1 000301", sec_tick, hms());
        end
        btn_inc = 1'b1; step(1); btn_inc = 1'b0;
        checks++;
        if (mode !== 2'b00 || hms() !== 24'h000301) begin
            errors++;
            $display("FAIL run_inc_ignored: got mode=%b time=%h, want 00 000301", mode, hms());
        end
    endtask

    task automatic test_rollover();
        do_reset();
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        pulse_inc(23);
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        step(236 + 3);
        checks++;
        if (hms() !== 24'h235959 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL pre_rollover: got %h tick=%b, want 235959 0", hms(), sec_tick);
        end
        step(1);
        checks++;
        if (hms() !== 24'h000000 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL rollover: got %h tick=%b, want 000000 1", hms(), sec_tick);
        end
    endtask

    task automatic test_reset_mid_carry();
        do_reset();
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        step(236 + 3);
        checks++;
        if (hms() !== 24'h005959) begin
            errors++;
            $display("FAIL pre_reset_carry: got %h, want 005959", hms());
        end
        rst = 1'b1; step(1); rst = 1'b0;
        checks++;
        if (hms() !== 24'h000000 || mode !== 2'b00 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_carry: got %h mode=%b tick=%b, want 000000 00 0",
                     hms(), mode, sec_tick);
        end
        step(3);
        checks++;
        if (sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early: got tick=%b, want 0", sec_tick);
        end
        step(1);
        checks++;
        if (sec_tick !== 1'b1 || hms() !== 24'h000001) begin
            errors++;
            $display("FAIL post_reset_tick: got tick=%b time=%h, want 1 000001", sec_tick, hms());
        end
    endtask

    initial begin
        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        test_reset();
        test_run();
        test_set_min();
        test_set_hour();
        test_simultaneous();
        test_rollover();
        test_reset_mid_carry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_clock_time_ctrl
